// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: generic valid/ready pipeline register chain with stall, flush and collapsing bubbles
module pipe_stage_chain #(
    parameter int STAGES      = 5,
    parameter int WIDTH       = 64,
    parameter bit ZERO_BUBBLE = 1,
    parameter int CNT_W       = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    input  logic [STAGES-1:0]                 stall,
    input  logic [STAGES-1:0]                 flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [STAGES-1:0]                 stage_valid,
    output logic [STAGES*WIDTH-1:0]           stage_data,
    output logic [$clog2(STAGES+1)-1:0]       occupancy,
    output logic [CNT_W-1:0]                  bp_cycles
);
    localparam int L  = STAGES - 1;
    localparam int OW = $clog2(STAGES + 1);
    logic [STAGES-1:0] v, mv, src_v, v_n;
    logic [STAGES:0] a;
    logic [STAGES*WIDTH-1:0] q, q_n, src_d;
    always_comb begin
        a = '0;
        mv = '0;
        a[STAGES] = out_ready;
        for (int k = L; k >= 0; k--) begin
            mv[k] = v[k] & ~stall[k] & a[k+1];
            a[k] = ~stall[k] & (~v[k] | mv[k]);
        end
    end
    assign in_ready = a[0];
    assign src_v = {mv[STAGES-2:0] & ~flush[STAGES-2:0], in_valid & a[0]};
    assign src_d = {q[(STAGES-1)*WIDTH-1:0], in_data};
    always_comb begin
        v_n = '0;
        q_n = '0;
        for (int k = 0; k < STAGES; k++) begin
            v_n[k] = a[k] ? src_v[k] : v[k] & ~flush[k];
            q_n[k*WIDTH +: WIDTH] = !v_n[k] ? (ZERO_BUBBLE ? '0 : q[k*WIDTH +: WIDTH]) :
                                    a[k] ? src_d[k*WIDTH +: WIDTH] : q[k*WIDTH +: WIDTH];
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
            q <= '0;
            occupancy <= '0;
            bp_cycles <= '0;
        end else begin
            v <= v_n;
            q <= q_n;
            occupancy <= OW'($countones(v_n));
            if (in_valid && !a[0] && !(&bp_cycles)) bp_cycles <= bp_cycles + CNT_W'(1);
        end
    end
    assign out_valid   = v[L] & ~flush[L];
    assign out_data    = q[L*WIDTH +: WIDTH];
    assign stage_valid = v;
    assign stage_data  = q;
endmodule
